mem_bank_model: RTL and testbench

- Synthesizable, parametrised single-bank memory model with independent write and read ports, each using a valid/ready handshake.
- Read responses come out of a configurable-latency pipeline. The pipeline supports backpressure, selectable read/write collision semantics and address range checking.
- Sits behind the AXI-to-memory bridge. Generalises the fixed 64-bit, latency-1, unchecked RAM model used by DMA testbenches and SoC scratchpads.

---
 rtl/mem_bank_model.sv | 144 ++++++++++++++
 tb/tb_mem_bank_model.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_model.sv
// Single-bank byte-strobed memory with valid/ready write and read ports and a stallable
// RD_LATENCY-deep response pipeline. Define MEM_BANK_MODEL_INIT_ZERO_EN to zero-fill after reset.
module mem_bank_model #(
   parameter int unsigned           DATA_WIDTH     = 64,
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           STRB_WIDTH     = DATA_WIDTH / 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int unsigned           BYTE_SIZE      = 32'h0001_0000,
   parameter int unsigned           DEPTH          = BYTE_SIZE / STRB_WIDTH,
   parameter int unsigned           RD_LATENCY     = 1,
   parameter int unsigned           COLLISION_MODE = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_valid,
   output logic                  o_wr_ready,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [STRB_WIDTH-1:0] i_wr_strb,
   output logic                  o_wr_err,
   input  logic                  i_rd_valid,
   output logic                  o_rd_ready,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_data,
   output logic                  o_rsp_err
);

   localparam int unsigned OFFS_W = $clog2(STRB_WIDTH);
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] ADDR_LO  = {1'b0, BASE_ADDR};
   localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH + 1)'(BYTE_SIZE);

   // One extra bit keeps a bank ending at the top of the address space from wrapping.
   function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] i_addr);
      logic [ADDR_WIDTH:0] w_off;
      w_off = {1'b0, i_addr} - ADDR_LO;
      return w_off < SIZE_EXT;
   endfunction

   function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_WIDTH-1:0] i_addr);
      return IDX_W'((i_addr - BASE_ADDR) >> OFFS_W);
   endfunction

   logic [DATA_WIDTH-1:0]                  r_mem [DEPTH];
   logic [RD_LATENCY-1:0]                  r_pv;
   logic [RD_LATENCY-1:0]                  r_pe;
   logic [RD_LATENCY-1:0][DATA_WIDTH-1:0]  r_pd;
   logic                                   r_wr_err;

   logic                  w_init_done;
   logic                  w_sweep_we;
   logic [IDX_W-1:0]      w_sweep_idx;
   logic                  w_stall;
   logic                  w_wr_fire;
   logic                  w_rd_fire;
   logic                  w_wr_in;
   logic                  w_rd_in;
   logic [IDX_W-1:0]      w_wr_idx;
   logic [IDX_W-1:0]      w_rd_idx;
   logic [DATA_WIDTH-1:0] w_rd_word;

`ifdef MEM_BANK_MODEL_INIT_ZERO_EN
   logic             r_init_busy;
   logic [IDX_W-1:0] r_init_idx;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_init_busy <= 1'b1;
         r_init_idx  <= '0;
      end else if (r_init_busy) begin
         r_init_idx <= r_init_idx + IDX_W'(1);
         if (r_init_idx == IDX_W'(DEPTH - 1)) r_init_busy <= 1'b0;
      end
   end

   assign w_init_done = ~r_init_busy;
   assign w_sweep_we  = r_init_busy & i_rst_n;
   assign w_sweep_idx = r_init_idx;
`else
   assign w_init_done = 1'b1;
   assign w_sweep_we  = 1'b0;
   assign w_sweep_idx = '0;
`endif

   assign w_stall    = r_pv[RD_LATENCY-1] & ~i_rsp_ready;
   assign o_wr_ready = i_rst_n & w_init_done;
   assign o_rd_ready = i_rst_n & w_init_done & ~w_stall;
   assign w_wr_fire  = i_wr_valid & o_wr_ready;
   assign w_rd_fire  = i_rd_valid & o_rd_ready;
   assign w_wr_in    = f_in_range(i_wr_addr);
   assign w_rd_in    = f_in_range(i_rd_addr);
   assign w_wr_idx   = f_index(i_wr_addr);
   assign w_rd_idx   = f_index(i_rd_addr);

   // Array is read at accept time; write-first mode forwards the strobed bytes of a same-edge write.
   always_comb begin
      w_rd_word = r_mem[w_rd_idx];
      if ((COLLISION_MODE != 0) && w_wr_fire && w_wr_in && (w_wr_idx == w_rd_idx)) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (i_wr_strb[i]) w_rd_word[8*i +: 8] = i_wr_data[8*i +: 8];
         end
      end
      if (!w_rd_in) w_rd_word = '0;
   end

   always_ff @(posedge i_clk) begin
      if (w_sweep_we) begin
         r_mem[w_sweep_idx] <= '0;
      end else if (w_wr_fire && w_wr_in) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (i_wr_strb[i]) r_mem[w_wr_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pv     <= '0;
         r_pe     <= '0;
         r_pd     <= '0;
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= w_wr_fire & ~w_wr_in;
         if (!w_stall) begin
            r_pv[0] <= w_rd_fire;
            r_pe[0] <= w_rd_fire & ~w_rd_in;
            r_pd[0] <= w_rd_fire ? w_rd_word : '0;
            for (int k = 1; k < RD_LATENCY; k++) begin
               r_pv[k] <= r_pv[k-1];
               r_pe[k] <= r_pe[k-1];
               r_pd[k] <= r_pd[k-1];
            end
         end
      end
   end

   assign o_wr_err    = r_wr_err;
   assign o_rsp_valid = r_pv[RD_LATENCY-1];
   assign o_rsp_err   = r_pe[RD_LATENCY-1];
   assign o_rsp_data  = r_pd[RD_LATENCY-1];

endmodule

// File: tb/tb_mem_bank_model.sv
// Directed bench for mem_bank_model: three instances (latency 1/3/4, mixed collision modes and
// bases, one bank ending at the top of the address space), exercised one at a time.
module tb_mem_bank_model;

`ifdef MEM_BANK_MODEL_INIT_ZERO_EN
   localparam int SweepCycles = 8192;
`else
   localparam int SweepCycles = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  sel;
   logic        wr_valid, rd_valid, rsp_ready;
   logic [31:0] wr_addr, rd_addr;
   logic [63:0] wr_data;
   logic [7:0]  wr_strb;

   logic [2:0]  d_wr_valid, d_rd_valid, d_rsp_ready;
   logic [2:0]  d_wr_ready, d_wr_err, d_rd_ready, d_rsp_valid, d_rsp_err;
   logic [63:0] d_rsp_data [3];

   logic        c_wr_ready, c_wr_err, c_rd_ready, c_rsp_valid, c_rsp_err;
   logic [63:0] c_rsp_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         d_wr_valid[k]  = wr_valid && (sel == 2'(k));
         d_rd_valid[k]  = rd_valid && (sel == 2'(k));
         d_rsp_ready[k] = (sel == 2'(k)) ? rsp_ready : 1'b1;
      end
      c_wr_ready  = d_wr_ready[sel];
      c_wr_err    = d_wr_err[sel];
      c_rd_ready  = d_rd_ready[sel];
      c_rsp_valid = d_rsp_valid[sel];
      c_rsp_err   = d_rsp_err[sel];
      c_rsp_data  = d_rsp_data[sel];
   end

   mem_bank_model #(.RD_LATENCY(1), .COLLISION_MODE(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_valid(d_wr_valid[0]), .o_wr_ready(d_wr_ready[0]), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_wr_strb(wr_strb), .o_wr_err(d_wr_err[0]),
      .i_rd_valid(d_rd_valid[0]), .o_rd_ready(d_rd_ready[0]), .i_rd_addr(rd_addr),
      .o_rsp_valid(d_rsp_valid[0]), .i_rsp_ready(d_rsp_ready[0]),
      .o_rsp_data(d_rsp_data[0]), .o_rsp_err(d_rsp_err[0])
   );

   mem_bank_model #(.RD_LATENCY(3), .COLLISION_MODE(1), .BASE_ADDR(32'h8000_0000)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_valid(d_wr_valid[1]), .o_wr_ready(d_wr_ready[1]), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_wr_strb(wr_strb), .o_wr_err(d_wr_err[1]),
      .i_rd_valid(d_rd_valid[1]), .o_rd_ready(d_rd_ready[1]), .i_rd_addr(rd_addr),
      .o_rsp_valid(d_rsp_valid[1]), .i_rsp_ready(d_rsp_ready[1]),
      .o_rsp_data(d_rsp_data[1]), .o_rsp_err(d_rsp_err[1])
   );

   mem_bank_model #(.RD_LATENCY(4), .COLLISION_MODE(0), .BASE_ADDR(32'hFFFF_0000)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_valid(d_wr_valid[2]), .o_wr_ready(d_wr_ready[2]), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_wr_strb(wr_strb), .o_wr_err(d_wr_err[2]),
      .i_rd_valid(d_rd_valid[2]), .o_rd_ready(d_rd_ready[2]), .i_rd_addr(rd_addr),
      .o_rsp_valid(d_rsp_valid[2]), .i_rsp_ready(d_rsp_ready[2]),
      .o_rsp_data(d_rsp_data[2]), .o_rsp_err(d_rsp_err[2])
   );

   function automatic int lat_of(input logic [1:0] k);
      case (k)
         2'd0:    return 1;
         2'd1:    return 3;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] base_of(input logic [1:0] k);
      case (k)
         2'd0:    return 32'h0000_0000;
         2'd1:    return 32'h8000_0000;
         default: return 32'hFFFF_0000;
      endcase
   endfunction

   function automatic logic [63:0] word_val(input int i);
      return 64'hC0DE_0000_0000_0000 | 64'(i);
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (dut %0d): got %h expected %h", tag, sel, got, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = addr; wr_data = data; wr_strb = strb;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Read, optionally with a write presented on the same edge; checks latency, data and error.
   task automatic do_rw(input logic [31:0] raddr, input bit wr_en, input logic [31:0] waddr,
                        input logic [63:0] wdata, input logic [7:0] wstrb, input string tag,
                        input logic [63:0] exp_data, input logic exp_err);
      int cyc;
      @(negedge clk);
      rsp_ready = 1'b1;
      rd_valid  = 1'b1; rd_addr = raddr;
      wr_valid  = wr_en; wr_addr = waddr; wr_data = wdata; wr_strb = wstrb;
      @(negedge clk);
      rd_valid = 1'b0; wr_valid = 1'b0;
      cyc = 1;
      while (!c_rsp_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check_eq({tag, "_lat"}, 64'(cyc), 64'(lat_of(sel)));
      check_eq({tag, "_data"}, c_rsp_data, exp_data);
      check_eq({tag, "_err"}, 64'(c_rsp_err), 64'(exp_err));
   endtask

   task automatic do_read(input logic [31:0] addr, input string tag, input logic [63:0] exp_data,
                          input logic exp_err);
      do_rw(addr, 1'b0, 32'h0, 64'h0, 8'h00, tag, exp_data, exp_err);
   endtask

   // Releases reset at a falling edge and counts cycles until the write port is ready.
   task automatic release_and_wait(input string tag, inout logic any_rsp);
      int cyc;
      rst_n = 1'b1;
      #1;
      cyc = 0;
      while (!(&d_wr_ready) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         any_rsp |= c_rsp_valid;
      end
      check_eq({tag, "_ready_delay"}, 64'(cyc), 64'(SweepCycles));
   endtask

   task automatic run_backpressure();
      logic [31:0] b;
      logic [63:0] snap;
      int          n_iss, n_rsp, stall_cyc, exp_w;
      int          q[$];
      logic        any_v;
      b = base_of(sel);
      for (int i = 0; i < 4; i++) do_write(b + 32'(8 * i), word_val(i), 8'hFF);
      n_iss = 0; n_rsp = 0; stall_cyc = 0; snap = '0;
      for (int c = 0; c < 40 && n_rsp < 4; c++) begin
         @(negedge clk);
         rsp_ready = (stall_cyc >= 5);
         rd_valid  = (n_iss < 4);
         rd_addr   = b + 32'(8 * n_iss);
         #1;
         if (c_rsp_valid && q.size() == 0) begin
            check_eq("bp_spurious_rsp", 64'(c_rsp_valid), 64'd0);
         end else if (c_rsp_valid && !rsp_ready) begin
            if (stall_cyc == 0) begin
               snap = c_rsp_data;
               check_eq("bp_first_data", c_rsp_data, word_val(q[0]));
            end else begin
               check_eq("bp_hold_data", c_rsp_data, snap);
            end
            check_eq("bp_rd_ready_low", 64'(c_rd_ready), 64'd0);
            stall_cyc++;
         end else if (c_rsp_valid) begin
            exp_w = q.pop_front();
            check_eq("bp_rsp_data", c_rsp_data, word_val(exp_w));
            n_rsp++;
         end
         if (rd_valid && c_rd_ready) begin
            q.push_back(n_iss);
            n_iss++;
         end
      end
      rd_valid = 1'b0; rsp_ready = 1'b1;
      check_eq("bp_rsp_count", 64'(n_rsp), 64'd4);
      any_v = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         any_v |= c_rsp_valid;
      end
      check_eq("bp_no_duplicate", 64'(any_v), 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] b;
      logic        any_rsp;
      rst_n = 1'b0; sel = 2'd0;
      wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
      wr_addr = '0; rd_addr = '0; wr_data = '0; wr_strb = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         check_eq("rst_rsp_valid", 64'(c_rsp_valid), 64'd0);
         check_eq("rst_rsp_data", c_rsp_data, 64'd0);
         check_eq("rst_rsp_err", 64'(c_rsp_err), 64'd0);
         check_eq("rst_wr_err", 64'(c_wr_err), 64'd0);
         check_eq("rst_wr_ready", 64'(c_wr_ready), 64'd0);
         check_eq("rst_rd_ready", 64'(c_rd_ready), 64'd0);
      end
      sel = 2'd0;
      any_rsp = 1'b0;
      release_and_wait("init", any_rsp);

      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         b = base_of(sel);
         do_write(b + 32'h10, 64'h1122334455667788, 8'hFF);
         check_eq("wr_err_inrange", 64'(c_wr_err), 64'd0);
         do_read(b + 32'h10, "basic", 64'h1122334455667788, 1'b0);
         do_write(b + 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
         do_read(b + 32'h13, "merge", 64'h11223344AAAAAAAA, 1'b0);
         do_write(b + 32'h10, 64'h5555555555555555, 8'h00);
         do_read(b + 32'h10, "strb_zero", 64'h11223344AAAAAAAA, 1'b0);
         do_write(b + 32'h20, 64'h0, 8'hFF);
         do_rw(b + 32'h20, 1'b1, b + 32'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF, "coll_full",
               (k == 1) ? 64'hFFFFFFFFFFFFFFFF : 64'h0, 1'b0);
         do_rw(b + 32'h24, 1'b1, b + 32'h20, 64'h0, 8'h0F, "coll_part",
               (k == 1) ? 64'hFFFFFFFF00000000 : 64'hFFFFFFFFFFFFFFFF, 1'b0);
         do_read(b + 32'h20, "coll_after", 64'hFFFFFFFF00000000, 1'b0);
         do_write(b, 64'h0123456789ABCDEF, 8'hFF);
         do_write(b + 32'h1_0000, 64'hDEADBEEFDEADBEEF, 8'hFF);
         check_eq("oor_wr_err", 64'(c_wr_err), 64'd1);
         @(negedge clk);
         check_eq("oor_wr_err_pulse", 64'(c_wr_err), 64'd0);
         do_read(b, "oor_wr_unchanged", 64'h0123456789ABCDEF, 1'b0);
         do_read(b + 32'h1_0000, "oor_rd", 64'h0, 1'b1);
         do_read(b - 32'h8, "below_base", 64'h0, 1'b1);
         do_write(b + 32'hFFF8, 64'hFEEDFACE12345678, 8'hFF);
         check_eq("top_wr_err", 64'(c_wr_err), 64'd0);
         do_read(b + 32'hFFFF, "top_byte", 64'hFEEDFACE12345678, 1'b0);
         run_backpressure();
      end

      // Two reads in flight on the latency-4 instance, then a one-cycle reset.
      sel = 2'd2;
      b = base_of(sel);
      rsp_ready = 1'b1;
      @(negedge clk);
      rd_valid = 1'b1; rd_addr = b;
      @(negedge clk);
      rd_addr = b + 32'h8;
      @(negedge clk);
      rd_valid = 1'b0; rst_n = 1'b0;
      #1;
      check_eq("midrst_wr_ready", 64'(c_wr_ready), 64'd0);
      check_eq("midrst_rd_ready", 64'(c_rd_ready), 64'd0);
      @(negedge clk);
      any_rsp = c_rsp_valid;
      release_and_wait("midrst", any_rsp);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         any_rsp |= c_rsp_valid;
      end
      check_eq("midrst_no_rsp", 64'(any_rsp), 64'd0);
      do_read(b + 32'h10, "post_rst_word", (SweepCycles != 0) ? 64'h0 : word_val(2), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
